multi_channel_dot_stage: RTL and testbench

Parametrised successor to the fixed 4-channel second-stage block. It buffers NUM_CHANNELS z vectors, each DEPTH elements long. It then computes ROWS fixed-point dot products per channel against a streamed m matrix and writes the rounded, saturated results to output RAM. It sits between the first-stage z producers and the output RAM, and requests m elements through a ready handshake.

---
 rtl/multi_channel_dot_stage.sv | 126 ++++++++++++
 tb/tb_multi_channel_dot_stage.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_dot_stage.sv
// multi_channel_dot_stage: buffers per-channel z vectors and writes rounded, saturated fixed-point dot products against a streamed m matrix to output RAM
module multi_channel_dot_stage #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_W = 16,
  parameter int DEPTH = 16,
  parameter int ROWS = 2,
  parameter int FRAC_BITS = 8,
  parameter int ADDR_W = 3
) (
  input  logic                           clock,
  input  logic                           clear_n,
  input  logic                           en,
  input  logic                           restart,
  input  logic [NUM_CHANNELS*DATA_W-1:0] z_elements,
  input  logic [NUM_CHANNELS-1:0]        z_elements_ready,
  output logic                           m_element_requested,
  input  logic                           m_element_ready,
  input  logic [DATA_W-1:0]              m_element,
  output logic [DATA_W-1:0]              output_ram_data,
  output logic [ADDR_W-1:0]              output_ram_address,
  output logic                           output_ram_write,
  output logic                           output_ram_enable,
  output logic                           overflow,
  output logic                           finished
);
  localparam int KW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int CW = NUM_CHANNELS > 1 ? $clog2(NUM_CHANNELS) : 1;
  localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int AW = 2 * DATA_W + KW;
  localparam logic [1:0] LOAD = 2'd0, MAC = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC_BITS - 1);

  logic [1:0] state;
  logic [DATA_W-1:0] cache [NUM_CHANNELS][DEPTH];
  logic [PW-1:0] wp [NUM_CHANNELS];
  logic [KW-1:0] k;
  logic [CW-1:0] ch;
  logic [RW-1:0] row;
  logic signed [AW-1:0] acc, rounded;
  logic signed [2*DATA_W-1:0] product;
  logic [DATA_W-1:0] result;
  logic all_full, strobe_drop, accept, wr;

  always_comb begin
    all_full = 1'b1;
    strobe_drop = 1'b0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      all_full = all_full && (wp[c] == PW'(DEPTH));
      strobe_drop = strobe_drop || (z_elements_ready[c] && (state != LOAD || wp[c] == PW'(DEPTH)));
    end
  end

  assign accept = state == MAC && en && m_element_ready;
  assign product = $signed(cache[ch][k]) * $signed(m_element);
  assign rounded = (acc + HALF) >>> FRAC_BITS;
  assign result = rounded > SAT_MAX ? SAT_MAX[DATA_W-1:0] :
                  rounded < SAT_MIN ? SAT_MIN[DATA_W-1:0] : rounded[DATA_W-1:0];
  assign wr = state == WRITE;
  assign output_ram_write = wr;
  assign output_ram_enable = wr;
  assign output_ram_data = wr ? result : '0;
  assign output_ram_address = wr ? ADDR_W'(ch * ROWS + row) : '0;
  assign m_element_requested = state == MAC && en;
  assign finished = state == DONE;

  // cache storage carries no reset; contents are only read after a full load
  always_ff @(posedge clock)
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (state == LOAD && z_elements_ready[c] && wp[c] != PW'(DEPTH))
        cache[c][wp[c][KW-1:0]] <= z_elements[c*DATA_W +: DATA_W];

  always_ff @(posedge clock or negedge clear_n)
    if (!clear_n) begin
      state <= LOAD;
      k <= '0;
      ch <= '0;
      row <= '0;
      acc <= '0;
      overflow <= 1'b0;
      for (int c = 0; c < NUM_CHANNELS; c++) wp[c] <= '0;
    end else begin
      if (strobe_drop) overflow <= 1'b1;
      case (state)
        LOAD: begin
          for (int c = 0; c < NUM_CHANNELS; c++)
            if (z_elements_ready[c] && wp[c] != PW'(DEPTH)) wp[c] <= wp[c] + 1'b1;
          if (all_full) begin
            state <= MAC;
            ch <= '0;
            row <= '0;
            k <= '0;
            acc <= '0;
          end
        end
        MAC:
          if (accept) begin
            acc <= acc + AW'(product);
            k <= k + 1'b1;
            if (k == KW'(DEPTH - 1)) state <= WRITE;
          end
        WRITE: begin
          acc <= '0;
          k <= '0;
          if (row != RW'(ROWS - 1)) begin
            row <= row + 1'b1;
            state <= MAC;
          end else if (ch != CW'(NUM_CHANNELS - 1)) begin
            row <= '0;
            ch <= ch + 1'b1;
            state <= MAC;
          end else state <= DONE;
        end
        default:
          if (restart) begin
            state <= LOAD;
            ch <= '0;
            row <= '0;
            k <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) wp[c] <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_multi_channel_dot_stage.sv
// tb_multi_channel_dot_stage: directed vectors checked against an arithmetic dot-product model of multi_channel_dot_stage
module tb_multi_channel_dot_stage;
  localparam int NC = 4, DW = 16, D = 16, R = 2, FB = 8, AW = 3;

  logic clock = 1'b0, clear_n = 1'b1, en = 1'b0, restart = 1'b0, m_element_ready = 1'b0;
  logic [NC*DW-1:0] z_elements = '0;
  logic [NC-1:0] z_elements_ready = '0;
  logic [DW-1:0] m_element = '0;
  logic m_element_requested, output_ram_write, output_ram_enable, overflow, finished;
  logic [DW-1:0] output_ram_data;
  logic [AW-1:0] output_ram_address;

  multi_channel_dot_stage dut (
    .clock(clock), .clear_n(clear_n), .en(en), .restart(restart),
    .z_elements(z_elements), .z_elements_ready(z_elements_ready),
    .m_element_requested(m_element_requested), .m_element_ready(m_element_ready),
    .m_element(m_element), .output_ram_data(output_ram_data),
    .output_ram_address(output_ram_address), .output_ram_write(output_ram_write),
    .output_ram_enable(output_ram_enable), .overflow(overflow), .finished(finished)
  );

  always #5 clock = ~clock;

  typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  int n_vec = 0, n_err = 0, nwr = 0;
  logic signed [DW-1:0] zm [NC][D];
  logic signed [DW-1:0] ms [NC*R*D+1];
  logic [DW-1:0] got [NC*R];
  wr_t expq[$];
  wr_t ce;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_sat(input longint acc);
    longint v;
    v = (acc + (64'sd1 <<< (FB - 1))) >>> FB;
    if (v > 32767) return 16'h7fff;
    if (v < -32768) return 16'h8000;
    return DW'(v);
  endfunction

  task automatic build_expect();
    longint acc;
    expq = {};
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < R; r++) begin
        acc = 0;
        for (int k = 0; k < D; k++) acc += longint'(zm[c][k]) * longint'(ms[(c*R+r)*D+k]);
        expq.push_back('{a: AW'(c*R+r), d: rnd_sat(acc)});
      end
    for (int a = 0; a < NC*R; a++) got[a] = '0;
  endtask

  task automatic prep(input logic [DW-1:0] zv, input logic [DW-1:0] mv);
    for (int c = 0; c < NC; c++) for (int k = 0; k < D; k++) zm[c][k] = zv;
    for (int i = 0; i <= NC*R*D; i++) ms[i] = mv;
  endtask

  task automatic load_all();
    for (int k = 0; k < D; k++) begin
      @(negedge clock);
      for (int c = 0; c < NC; c++) z_elements[c*DW +: DW] = zm[c][k];
      z_elements_ready = '1;
    end
    @(negedge clock);
    z_elements_ready = '0;
  endtask

  task automatic run(input int stall_at, input bit toggle, output int cyc, output int lw);
    int t, mi;
    bit started;
    t = 0; mi = 0; started = 0; cyc = -1; lw = -1;
    for (int i = 0; i < 3000 && cyc < 0; i++) begin
      @(negedge clock);
      if (finished) cyc = t;
      else begin
        if (output_ram_write) lw = t;
        en = !(started && t >= stall_at && t < stall_at + 5);
        m_element_ready = toggle ? (i % 2 == 0) : 1'b1;
        m_element = ms[mi];
        #1;
        if (!en) check("req_while_stalled", m_element_requested, 0);
        if (m_element_requested) started = 1;
        if (m_element_requested && m_element_ready) mi++;
        if (started) t++;
      end
    end
    en = 1'b1;
    m_element_ready = 1'b0;
    check("run_completes", cyc >= 0, 1);
    check("writes_drained", expq.size(), 0);
  endtask

  task automatic do_restart();
    @(negedge clock);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("restart_clears_finished", finished, 0);
    #1 check("load_no_request", m_element_requested, 0);
  endtask

  always @(negedge clock)
    if (clear_n && output_ram_write) begin
      if (expq.size() == 0) check("spurious_write", output_ram_write, 0);
      else begin
        ce = expq.pop_front();
        check("ram_addr", output_ram_address, ce.a);
        check("ram_data", output_ram_data, ce.d);
        check("ram_enable", output_ram_enable, 1);
        got[output_ram_address] = output_ram_data;
        nwr++;
      end
    end

  initial begin
    int cyc, lw, base;
    #1 clear_n = 1'b0;
    #2;
    check("rst_req", m_element_requested, 0);
    check("rst_data", output_ram_data, 0);
    check("rst_addr", output_ram_address, 0);
    check("rst_write", output_ram_write, 0);
    check("rst_enable", output_ram_enable, 0);
    check("rst_overflow", overflow, 0);
    check("rst_finished", finished, 0);
    @(negedge clock);
    clear_n = 1'b1;
    en = 1'b1;

    prep(16'h0100, 16'h0100);
    load_all(); build_expect(); run(1000, 0, cyc, lw);
    check("basic_cycles", cyc, 136);
    check("finished_after_last_write", cyc, lw + 1);
    for (int a = 0; a < NC*R; a++) check("basic_word", got[a], 16'h1000);
    check("no_overflow_yet", overflow, 0);
    do_restart();

    prep(16'h7fff, 16'h7fff);
    load_all(); build_expect(); run(1000, 0, cyc, lw);
    check("pos_sat", got[5], 16'h7fff);
    do_restart();
    prep(16'h8000, 16'h7fff);
    load_all(); build_expect(); run(1000, 0, cyc, lw);
    check("neg_sat", got[2], 16'h8000);
    do_restart();

    prep(16'h0000, 16'h0080);
    for (int k = 0; k < D; k++) zm[0][k] = 16'h0001;
    load_all(); build_expect(); run(1000, 0, cyc, lw);
    check("round_sum", got[0], 16'h0008);
    do_restart();
    prep(16'h0000, 16'h0080);
    zm[0][0] = 16'h0001;
    load_all(); build_expect(); run(1000, 0, cyc, lw);
    check("round_half_up", got[0], 16'h0001);
    do_restart();

    prep(16'h0100, 16'h0100);
    for (int k = 0; k < D; k++) zm[0][k] = DW'(k + 1);
    for (int k = 0; k < 17; k++) begin
      @(negedge clock);
      z_elements[0 +: DW] = k < D ? zm[0][k] : 16'h7fff;
      z_elements_ready = 4'b0001;
    end
    @(negedge clock);
    z_elements_ready = '0;
    check("overflow_on_full", overflow, 1);
    @(negedge clock);
    #1 check("waits_for_fill", m_element_requested, 0);
    for (int k = 0; k < D; k++) begin
      @(negedge clock);
      for (int c = 1; c < NC; c++) z_elements[c*DW +: DW] = zm[c][k];
      z_elements_ready = 4'b1110;
    end
    @(negedge clock);
    z_elements_ready = '0;
    build_expect(); run(1000, 0, cyc, lw);
    check("first16_only", got[0], 16'h0088);
    do_restart();
    check("overflow_sticky", overflow, 1);

    for (int c = 0; c < NC; c++) for (int k = 0; k < D; k++) zm[c][k] = DW'(((c*D+k)*37) % 511 - 255);
    for (int i = 0; i <= NC*R*D; i++) ms[i] = DW'((i*53) % 601 - 300);
    load_all(); build_expect(); run(5, 0, cyc, lw);
    check("stall_cycles", cyc, 141);
    do_restart();
    load_all(); build_expect(); run(1000, 1, cyc, lw);
    do_restart();

    prep(16'h0100, 16'h0100);
    load_all(); build_expect();
    base = nwr;
    m_element = 16'h0100;
    for (int i = 0; i < 500 && nwr < base + 3; i++) begin
      @(negedge clock);
      m_element_ready = 1'b1;
    end
    repeat (4) @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    check("abort_write", output_ram_write, 0);
    check("abort_enable", output_ram_enable, 0);
    check("abort_data", output_ram_data, 0);
    check("abort_addr", output_ram_address, 0);
    check("abort_req", m_element_requested, 0);
    check("abort_overflow", overflow, 0);
    expq = {};
    repeat (3) @(negedge clock);
    clear_n = 1'b1;
    repeat (3) @(negedge clock);
    base = nwr;
    load_all(); build_expect(); run(1000, 0, cyc, lw);
    check("rerun_write_count", nwr - base, 8);
    check("rerun_word", got[7], 16'h1000);
    check("rerun_cycles", cyc, 136);

    @(negedge clock);
    z_elements_ready = 4'b0100;
    @(negedge clock);
    z_elements_ready = '0;
    check("done_strobe_overflow", overflow, 1);
    check("done_holds", finished, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
